hud_digit_plotter: RTL and testbench

- Downstream consumer of the timer_display and score_display BCD digits.
- On each frame tick it latches the concatenated digit vector and serially paints every digit as a 3x5 glyph into the VGA adapter pixel interface (x/y/colour/plot), one pixel per clock.
- It sits between the game counters and the vga_adapter instance and replaces HEX-only readout with an on-screen HUD.

---
 rtl/hud_pkg.sv | 34 +++
 rtl/hud_glyph_rom.sv | 17 +
 rtl/hud_digit_plotter.sv | 140 ++++++++++++++
 tb/tb_hud_digit_plotter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/hud_pkg.sv
// rtl/hud_pkg.sv - shared HUD glyph geometry, FSM states and 3x5 digit font
package hud_pkg;

    localparam int GLYPH_W    = 3;
    localparam int GLYPH_H    = 5;
    localparam int SLOT_PITCH = 4;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DONE
    } state_t;

    // Row 0 is the top row; bit 2 of each row is the leftmost glyph column.
    localparam logic [2:0] GLYPH [16][5] = '{
        '{3'b111, 3'b101, 3'b101, 3'b101, 3'b111},
        '{3'b010, 3'b110, 3'b010, 3'b010, 3'b111},
        '{3'b111, 3'b001, 3'b111, 3'b100, 3'b111},
        '{3'b111, 3'b001, 3'b111, 3'b001, 3'b111},
        '{3'b101, 3'b101, 3'b111, 3'b001, 3'b001},
        '{3'b111, 3'b100, 3'b111, 3'b001, 3'b111},
        '{3'b111, 3'b100, 3'b111, 3'b101, 3'b111},
        '{3'b111, 3'b001, 3'b001, 3'b001, 3'b001},
        '{3'b111, 3'b101, 3'b111, 3'b101, 3'b111},
        '{3'b111, 3'b101, 3'b111, 3'b001, 3'b111},
        '{3'b000, 3'b000, 3'b111, 3'b000, 3'b000},
        '{3'b000, 3'b000, 3'b111, 3'b000, 3'b000},
        '{3'b000, 3'b000, 3'b111, 3'b000, 3'b000},
        '{3'b000, 3'b000, 3'b111, 3'b000, 3'b000},
        '{3'b000, 3'b000, 3'b111, 3'b000, 3'b000},
        '{3'b000, 3'b000, 3'b111, 3'b000, 3'b000}
    };

endpackage

// File: rtl/hud_glyph_rom.sv
// rtl/hud_glyph_rom.sv - combinational lookup of one 3-bit glyph row
module hud_glyph_rom
    import hud_pkg::*;
(
    input  logic [3:0] digit,
    input  logic [2:0] row,
    output logic [2:0] bits
);

    always_comb begin
        bits = 3'b000;
        if (row < 3'(GLYPH_H)) begin
            bits = GLYPH[digit][row];
        end
    end

endmodule

// File: rtl/hud_digit_plotter.sv
// rtl/hud_digit_plotter.sv - paints latched BCD digits as 3x5 glyphs, one pixel per clock (HUD_LEADING_BLANK_EN blanks leading zeros)
module hud_digit_plotter
    import hud_pkg::*;
#(
    parameter int         NUM_DIGITS = 6,
    parameter logic [7:0] ORIGIN_X   = 8'd0,
    parameter logic [6:0] ORIGIN_Y   = 7'd0,
    parameter logic [2:0] FG_COLOUR  = 3'b111,
    parameter logic [2:0] BG_COLOUR  = 3'b000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] digits,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              x,
    output logic [6:0]              y,
    output logic [2:0]              colour,
    output logic                    plot
);

    localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_DIGITS - 1);

    state_t                  state;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [SLOT_W-1:0]       slot;
    logic [2:0]              row;
    logic [1:0]              col;
    logic [3:0]              cur_digit;
    logic [2:0]              glyph_bits;
    logic                    glyph_bit;
    logic                    blank;
    logic                    lit;
    logic                    last_pixel;
`ifdef HUD_LEADING_BLANK_EN
    logic                    lead_zero;
`endif

    // Slot 0 is leftmost and shows the most significant digit.
    always_comb begin
        cur_digit = 4'd0;
        blank     = 1'b0;
`ifdef HUD_LEADING_BLANK_EN
        lead_zero = 1'b1;
`endif
        for (int s = 0; s < NUM_DIGITS; s++) begin
`ifdef HUD_LEADING_BLANK_EN
            lead_zero = lead_zero && (shadow[4*(NUM_DIGITS-1-s) +: 4] == 4'd0);
`endif
            if (slot == SLOT_W'(s)) begin
                cur_digit = shadow[4*(NUM_DIGITS-1-s) +: 4];
`ifdef HUD_LEADING_BLANK_EN
                blank = lead_zero && (s != NUM_DIGITS - 1);
`endif
            end
        end
    end

    hud_glyph_rom u_glyph_rom (
        .digit (cur_digit),
        .row   (row),
        .bits  (glyph_bits)
    );

    always_comb begin
        case (col)
            2'd0:    glyph_bit = glyph_bits[2];
            2'd1:    glyph_bit = glyph_bits[1];
            2'd2:    glyph_bit = glyph_bits[0];
            default: glyph_bit = 1'b0;
        endcase
        lit        = glyph_bit && !blank;
        last_pixel = (slot == LAST_SLOT) && (row == 3'(GLYPH_H - 1))
                     && (col == 2'(SLOT_PITCH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            shadow <= '0;
            slot   <= '0;
            row    <= '0;
            col    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= BG_COLOUR;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    plot <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        shadow <= digits;
                        slot   <= '0;
                        row    <= '0;
                        col    <= '0;
                        state  <= DRAW;
                    end
                end
                DRAW: begin
                    plot   <= 1'b1;
                    busy   <= 1'b1;
                    x      <= ORIGIN_X + 8'(slot) * 8'(SLOT_PITCH) + 8'(col);
                    y      <= ORIGIN_Y + 7'(row);
                    colour <= lit ? FG_COLOUR : BG_COLOUR;
                    if (last_pixel) begin
                        slot  <= '0;
                        row   <= '0;
                        col   <= '0;
                        state <= DONE;
                    end else if (col == 2'(SLOT_PITCH - 1)) begin
                        col <= '0;
                        if (row == 3'(GLYPH_H - 1)) begin
                            row  <= '0;
                            slot <= slot + SLOT_W'(1);
                        end else begin
                            row <= row + 3'd1;
                        end
                    end else begin
                        col <= col + 2'd1;
                    end
                end
                DONE: begin
                    plot  <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hud_digit_plotter.sv
// tb/tb_hud_digit_plotter.sv - randomized frame checks against a pixel-list reference model
module tb_hud_digit_plotter;
    import hud_pkg::*;

    localparam int N    = 6;
    localparam int NPIX = 20 * N;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] digits;
    logic        busy;
    logic        done;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic [31:0] obs;

    int n_checks = 0;
    int n_errors = 0;

    hud_digit_plotter #(
        .NUM_DIGITS (N),
        .ORIGIN_X   (8'd0),
        .ORIGIN_Y   (7'd0),
        .FG_COLOUR  (3'b111),
        .BG_COLOUR  (3'b000)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .digits (digits),
        .busy   (busy),
        .done   (done),
        .x      (x),
        .y      (y),
        .colour (colour),
        .plot   (plot)
    );

    always #5 clk = ~clk;

    assign obs = {11'd0, plot, busy, done, x, y, colour};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected {plot,busy,done,x,y,colour} for the p-th pixel of a frame showing d.
    function automatic logic [31:0] exp_pixel(input logic [23:0] d, input int p);
        int          s = p / 20;
        int          r = (p % 20) / 4;
        int          c = p % 4;
        logic [3:0]  dig;
        logic [2:0]  g;
        logic        on;
        logic        blank;
        dig   = d[4*(N-1-s) +: 4];
        g     = GLYPH[dig][r];
        on    = (c < 3) ? g[2-c] : 1'b0;
        blank = 1'b0;
`ifdef HUD_LEADING_BLANK_EN
        blank = (s != N - 1);
        for (int i = 0; i <= s; i++) begin
            if (d[4*(N-1-i) +: 4] != 4'd0) blank = 1'b0;
        end
`endif
        if (blank) on = 1'b0;
        return {11'd0, 1'b1, 1'b1, 1'b0, 8'((4 * s + c) % 256), 7'(r), on ? 3'b111 : 3'b000};
    endfunction

    task automatic run_frame(input logic [23:0] d, input int start_a, input int start_b,
                             input int chg_at, input logic [23:0] chg_d,
                             input bit poke_done, input string tag);
        logic [23:0] ref_d;
        ref_d = d;
        @(posedge clk); #1;
        digits = d;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int p = 0; p < NPIX; p++) begin
            @(posedge clk); #1;
            start = 1'b0;
            check($sformatf("%s px%0d", tag, p), obs, exp_pixel(ref_d, p));
            if (p == start_a || p == start_b) start = 1'b1;
            if (p == chg_at) digits = chg_d;
        end
        if (poke_done) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check($sformatf("%s done", tag), 32'(obs[20:18]), 32'(3'b001));
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check($sformatf("%s idle%0d", tag, k), 32'(obs[20:18]), 32'(3'b000));
        end
    endtask

    task automatic run_reset_mid(input logic [23:0] d);
        @(posedge clk); #1;
        digits = d;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int p = 0; p <= 50; p++) begin
            @(posedge clk); #1;
            check($sformatf("rst px%0d", p), obs, exp_pixel(d, p));
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst stop", 32'(obs[20:18]), 32'(3'b000));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("rst quiet%0d", k), 32'(obs[20:18]), 32'(3'b000));
        end
    endtask

    initial begin
        logic [23:0] rd;
        logic [23:0] rc;
        reset  = 1'b1;
        start  = 1'b0;
        digits = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", obs, 32'd0);
        reset = 1'b0;

        run_frame(24'h000001, -1, -1, -1, 24'h0, 1'b0, "sweep");
        run_frame(24'h123456, 10, 60, -1, 24'h0, 1'b1, "ignore");
        run_reset_mid(24'h987654);
        run_frame(24'h987654, -1, -1, -1, 24'h0, 1'b0, "after_rst");
        run_frame(24'hA00000, -1, -1, -1, 24'h0, 1'b0, "dash");
        run_frame(24'h111111, -1, -1, 30, 24'h000000, 1'b0, "latch");
        run_frame(24'h000120, -1, -1, -1, 24'h0, 1'b0, "lead120");
        run_frame(24'h000000, -1, -1, -1, 24'h0, 1'b0, "zero");

        for (int i = 0; i < 6; i++) begin
            rd = 24'($urandom);
            rc = 24'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_frame(rd, $urandom_range(0, NPIX - 1), -1, $urandom_range(0, NPIX - 1),
                      rc, i[0], $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
